// File: rtl/ap_ctrl_driver_if.sv
// ap_ctrl_driver_if: ap_ctrl_chain handshake bundle between the control driver and one HLS kernel.
//   ap_start    driver -> kernel  start request, held until ap_ready
//   ap_continue driver -> kernel  downstream acceptance of ap_done
//   ap_ready    kernel -> driver  kernel accepted the current start
//   ap_done     kernel -> driver  result valid, held until ap_continue
// master = control driver side, slave = kernel side.
interface ap_ctrl_driver_if;
    logic ap_start;
    logic ap_continue;
    logic ap_ready;
    logic ap_done;

    modport master (
        output ap_start,
        output ap_continue,
        input  ap_ready,
        input  ap_done
    );

    modport slave (
        input  ap_start,
        input  ap_continue,
        output ap_ready,
        output ap_done
    );
endinterface

// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_driver: issues a programmed number of ap_ctrl_chain transactions to one kernel and
// raises finish once every issued transaction has completed.
// Ports:
//   clock       single clock, rising edge
//   reset       synchronous, active-low
//   go          level run request; low returns to idle after finish
//   trans_num   transaction count, sampled in idle when go=1
//   cont_hold   sink backpressure, forces ap_continue low
//   kif         kernel handshake (ap_start/ap_continue out, ap_ready/ap_done in)
//   finish      all transactions complete
//   busy        run or drain in progress
//   issued_cnt  start handshakes in this run
//   done_cnt    completion handshakes in this run
//   err         sticky: completion seen with nothing outstanding
module ap_ctrl_driver #(
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 go,
    input  logic [CNT_W-1:0]     trans_num,
    input  logic                 cont_hold,
    ap_ctrl_driver_if.master     kif,
    output logic                 finish,
    output logic                 busy,
    output logic [CNT_W-1:0]     issued_cnt,
    output logic [CNT_W-1:0]     done_cnt,
    output logic                 err
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFinish} state_e;

    localparam logic [CNT_W-1:0] MaxOut = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] One    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] done_q, done_d;
    logic [CNT_W-1:0] outstanding, outstanding_d;
    logic             err_q, err_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             finish_q, finish_d;
    logic             start_hs, done_ev, done_hs;

    assign outstanding = issued_q - done_q;

    // Continue is offered even with nothing outstanding: the kernel may wait for it before done.
    assign kif.ap_continue = busy_q & ~cont_hold;

    assign start_hs = start_q & kif.ap_ready;
    assign done_ev  = kif.ap_done & kif.ap_continue;
    assign done_hs  = done_ev & (outstanding != '0);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        issued_d = issued_q;
        done_d   = done_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (go) begin
                    if (trans_num != '0) begin
                        target_d = trans_num;
                        issued_d = '0;
                        done_d   = '0;
                        err_d    = 1'b0;
                        state_d  = StRun;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StRun, StDrain: begin
                if (start_hs) issued_d = issued_q + One;
                if (done_hs)  done_d   = done_q + One;
                if (done_ev && (outstanding == '0)) err_d = 1'b1;
                // Last start and last completion in one cycle skip drain entirely.
                if ((issued_d == target_q) && (done_d == target_q)) begin
                    state_d = StFinish;
                end else if (issued_d == target_q) begin
                    state_d = StDrain;
                end
            end
            StFinish: begin
                if (!go) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are computed from next-state values so they can be registered without lag.
        outstanding_d = issued_d - done_d;
        start_d  = (state_d == StRun) && (issued_d < target_d) && (outstanding_d < MaxOut);
        busy_d   = (state_d == StRun) || (state_d == StDrain);
        finish_d = (state_d == StFinish);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= StIdle;
            target_q <= '0;
            issued_q <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            issued_q <= issued_d;
            done_q   <= done_d;
            err_q    <= err_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
        end
    end

    assign kif.ap_start = start_q;
    assign finish       = finish_q;
    assign busy         = busy_q;
    assign issued_cnt   = issued_q;
    assign done_cnt     = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// tb_ap_ctrl_driver: self-checking bench for ap_ctrl_driver with a behavioural kernel model.
`timescale 1ns/1ps
module tb_ap_ctrl_driver;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned MAX_OUT = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             go = 1'b0;
    logic             cont_hold = 1'b0;
    logic [CNT_W-1:0] trans_num = '0;
    logic             finish, busy, err;
    logic [CNT_W-1:0] issued_cnt, done_cnt;

    ap_ctrl_driver_if kif ();

    ap_ctrl_driver #(
        .CNT_W           (CNT_W),
        .MAX_OUTSTANDING (MAX_OUT)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .go         (go),
        .trans_num  (trans_num),
        .cont_hold  (cont_hold),
        .kif        (kif),
        .finish     (finish),
        .busy       (busy),
        .issued_cnt (issued_cnt),
        .done_cnt   (done_cnt),
        .err        (err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Kernel model: ready level, done after a fixed latency, done held until continue.
    int  done_lat   = 4;
    bit  ready_en   = 1'b1;
    bit  spurious   = 1'b0;
    bit  kclr       = 1'b0;
    int  pend[$];
    int  cyc        = 0;
    bit  last_start = 1'b0;
    bit  last_done  = 1'b0;
    bit  dcount;
    int  mo         = 0;
    int  overlap    = 0;

    always @(negedge clock) begin
        if (kclr) begin
            pend.delete();
            mo         = 0;
            last_start = 1'b0;
            last_done  = 1'b0;
            kclr       = 1'b0;
        end
        if (last_done && pend.size() > 0) void'(pend.pop_front());
        if (last_start) pend.push_back(cyc + done_lat - 1);
        kif.ap_ready = ready_en;
        kif.ap_done  = spurious || (pend.size() > 0 && pend[0] <= cyc);
        #4;
        // Just before the rising edge: what the DUT is about to sample.
        last_start = kif.ap_start && kif.ap_ready;
        last_done  = kif.ap_done && kif.ap_continue;
        if (busy && reset) begin
            chk("outstanding", 32'(issued_cnt - done_cnt), mo);
            if (mo >= int'(MAX_OUT)) chk("start_low_at_max", 32'(kif.ap_start), 0);
        end
        dcount = last_done && (mo > 0);
        if (last_start && dcount) overlap++;
        mo = mo + int'(last_start) - int'(dcount);
        cyc++;
    end

    typedef struct {
        logic [CNT_W-1:0] issued;
        logic [CNT_W-1:0] done;
        logic             err;
    } exp_t;

    typedef struct {
        int               n;
        int               lat;
        logic [CNT_W-1:0] exp_issued;
        logic [CNT_W-1:0] exp_done;
        logic             exp_err;
    } vec_t;

    exp_t sb[$];

    task automatic to_drive();
        @(negedge clock);
        #1;
    endtask

    task automatic to_check();
        @(posedge clock);
        #2;
    endtask

    task automatic start_run(input int n);
        to_drive();
        go        = 1'b1;
        trans_num = CNT_W'(n);
        kclr      = 1'b1;
    endtask

    // Waits (bounded) for finish, then pops the expected end state from the scoreboard.
    task automatic wait_finish(input string tag, output int k);
        exp_t e;
        k = 0;
        while (finish !== 1'b1 && k < 300) begin
            to_check();
            k++;
        end
        chk({tag, "_finish"}, 32'(finish), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_issued"}, 32'(issued_cnt), 32'(e.issued));
            chk({tag, "_done"}, 32'(done_cnt), 32'(e.done));
            chk({tag, "_err"}, 32'(err), 32'(e.err));
            chk({tag, "_start_low"}, 32'(kif.ap_start), 0);
        end
    endtask

    task automatic end_run(input string tag);
        to_drive();
        go = 1'b0;
        to_check();
        chk({tag, "_idle"}, 32'({finish, busy}), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int   k;
        vecs[0] = '{n: 3, lat: 4, exp_issued: 16'd3, exp_done: 16'd3, exp_err: 1'b0};
        vecs[1] = '{n: 5, lat: 5, exp_issued: 16'd5, exp_done: 16'd5, exp_err: 1'b0};
        vecs[2] = '{n: 1, lat: 1, exp_issued: 16'd1, exp_done: 16'd1, exp_err: 1'b0};
        vecs[3] = '{n: 4, lat: 1, exp_issued: 16'd4, exp_done: 16'd4, exp_err: 1'b0};
        vecs[4] = '{n: 6, lat: 2, exp_issued: 16'd6, exp_done: 16'd6, exp_err: 1'b0};

        // Reset state
        kclr = 1'b1;
        repeat (3) to_check();
        chk("rst_ctrl", 32'({kif.ap_start, kif.ap_continue, finish, busy, err}), 0);
        chk("rst_issued", 32'(issued_cnt), 0);
        chk("rst_done", 32'(done_cnt), 0);
        to_drive();
        reset = 1'b1;
        to_check();

        // Zero count: straight to finish, held while go stays high
        start_run(0);
        to_check();
        chk("zero_finish", 32'(finish), 1);
        chk("zero_busy_start", 32'({busy, kif.ap_start}), 0);
        repeat (3) to_check();
        chk("zero_hold", 32'({finish, busy, kif.ap_start}), 32'b100);
        end_run("zero");

        // Table-driven runs
        for (int i = 0; i < 5; i++) begin
            done_lat = vecs[i].lat;
            ready_en = 1'b1;
            start_run(vecs[i].n);
            sb.push_back('{issued: vecs[i].exp_issued, done: vecs[i].exp_done,
                           err: vecs[i].exp_err});
            to_check();
            chk($sformatf("v%0d_first_start", i), 32'({kif.ap_start, busy}), 32'b11);
            wait_finish($sformatf("v%0d", i), k);
            end_run($sformatf("v%0d", i));
        end
        chk("same_cycle_start_done_seen", 32'(overlap > 0), 1);

        // Minimum latency: one transaction, single-cycle kernel
        done_lat = 1;
        start_run(1);
        sb.push_back('{issued: 16'd1, done: 16'd1, err: 1'b0});
        wait_finish("lat", k);
        chk("lat_cycles", k, 3);
        end_run("lat");

        // Backpressure: done held while continue is blocked
        done_lat = 1;
        start_run(2);
        cont_hold = 1'b1;
        repeat (10) to_check();
        chk("bp_continue", 32'(kif.ap_continue), 0);
        chk("bp_ap_done_held", 32'(kif.ap_done), 1);
        chk("bp_done_frozen", 32'(done_cnt), 0);
        chk("bp_issued", 32'(issued_cnt), 2);
        chk("bp_no_finish", 32'(finish), 0);
        to_drive();
        cont_hold = 1'b0;
        sb.push_back('{issued: 16'd2, done: 16'd2, err: 1'b0});
        wait_finish("bp", k);
        end_run("bp");

        // Spurious done before any start
        ready_en = 1'b0;
        spurious = 1'b1;
        start_run(2);
        to_check();
        to_check();
        chk("spur_err", 32'(err), 1);
        chk("spur_done_cnt", 32'(done_cnt), 0);
        to_drive();
        spurious = 1'b0;
        ready_en = 1'b1;
        done_lat = 2;
        sb.push_back('{issued: 16'd2, done: 16'd2, err: 1'b1});
        wait_finish("spur", k);
        end_run("spur");
        start_run(1);
        to_check();
        chk("spur_err_cleared", 32'(err), 0);
        sb.push_back('{issued: 16'd1, done: 16'd1, err: 1'b0});
        wait_finish("spur_rerun", k);
        end_run("spur_rerun");

        // Reset mid-run after two starts
        done_lat = 20;
        start_run(5);
        k = 0;
        while (issued_cnt !== 16'd2 && k < 50) begin
            to_check();
            k++;
        end
        chk("mr_two_issued", 32'(issued_cnt), 2);
        to_drive();
        reset = 1'b0;
        go    = 1'b0;
        to_check();
        chk("mr_ctrl", 32'({kif.ap_start, kif.ap_continue, finish, busy, err}), 0);
        chk("mr_counts", 32'({issued_cnt, done_cnt}), 0);
        to_drive();
        reset = 1'b1;
        kclr  = 1'b1;
        done_lat = 3;
        start_run(5);
        sb.push_back('{issued: 16'd5, done: 16'd5, err: 1'b0});
        wait_finish("mr_rerun", k);
        end_run("mr_rerun");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/ap_ctrl_driver.md
# ap_ctrl_driver

Block-level control driver for one HLS kernel using the ap_ctrl_chain protocol (ap_start/ap_ready/ap_done/ap_continue). It issues a programmed number of transactions and tracks their completion. It raises `finish` once every issued transaction has been acknowledged, and this `finish` is the signal consumed by the dataflow/module-status monitors. It sits in the simulation top between the testbench sequencer and the kernel instance, and its RTL is synthesizable so the same block can drive the kernel on hardware.

## Interface
Parameters:
- CNT_W, 16, width of transaction count, issued/completed counters
- MAX_OUTSTANDING, 2, max transactions started but not yet completed (1..2^CNT_W-1)

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- go  in  1  level; rising run request, low returns block to idle after finish
- trans_num  in  CNT_W  number of transactions; sampled in IDLE when go=1
- cont_hold  in  1  sink backpressure; 1 forces ap_continue=0
- ap_ready  in  1  kernel accepted current start
- ap_done  in  1  kernel result valid, held until continue
- ap_start  out  1  start request to kernel
- ap_continue  out  1  downstream acceptance of ap_done
- finish  out  1  all transactions complete
- busy  out  1  state is RUN or DRAIN
- issued_cnt  out  CNT_W  starts handshaken
- done_cnt  out  CNT_W  completions handshaken
- err  out  1  sticky: ap_done+ap_continue seen with zero outstanding

## Operation
- Start handshake: ap_start && ap_ready in the same cycle. Completion handshake: ap_done && ap_continue in the same cycle, counted only when outstanding > 0.
- outstanding = issued_cnt - done_cnt (CNT_W bits, never negative, never > MAX_OUTSTANDING).
- FSM states IDLE, RUN, DRAIN, FINISH. Register `target` holds the latched trans_num.
- IDLE: go=1 and trans_num≠0 → latch target, clear counters, clear err, go to RUN. go=1 and trans_num=0 → go to FINISH.
- RUN: ap_start = (issued_cnt < target) && (outstanding < MAX_OUTSTANDING). A start handshake that makes issued_cnt == target → DRAIN next cycle. If that same cycle also makes done_cnt == target → FINISH directly.
- DRAIN: ap_start=0. When done_cnt reaches target → FINISH.
- FINISH: finish=1. go=0 → IDLE. go held high stays in FINISH; no auto-restart.
- ap_continue = busy && !cont_hold. It is also asserted when outstanding=0, because the kernel may assert ap_done only after continue.
- A start and a completion in the same cycle leave outstanding unchanged; both counters still increment.
- ap_done && ap_continue with outstanding=0 sets err and is not counted. err clears only on reset or on a new run from IDLE.
- ap_ready without ap_start is ignored. ap_start never drops before its handshake except on reset.

## Timing
- Reset (reset=0 at an edge): state IDLE; ap_start, ap_continue, finish, busy, err = 0; issued_cnt = done_cnt = target = 0. Reset applied mid-run aborts immediately; the kernel is not drained.
- ap_start, finish, busy are decoded from registered state only, with no combinational path from inputs. ap_continue has a single combinational path from cont_hold.
- IDLE→RUN: first ap_start is high in the cycle after the edge that samples go=1.
- With ap_ready tied high and MAX_OUTSTANDING not reached, ap_start stays high and issues one start per cycle.
- Counters update on the edge of the handshake cycle. ap_start deasserts in the cycle after the handshake that reaches target or MAX_OUTSTANDING.
- finish rises the cycle after the final completion handshake. Minimum go→finish latency for N transactions with single-cycle kernel response is N+2 cycles.

## Test plan
- Basic: MAX_OUTSTANDING=1, trans_num=3, kernel asserts ap_ready with start and ap_done 4 cycles later, cont_hold=0 → exactly 3 start handshakes, issued_cnt=done_cnt=3, finish=1, err=0.
- Pipelined: MAX_OUTSTANDING=2, ap_ready tied 1, done latency 5 → outstanding never exceeds 2; ap_start low while outstanding=2; same-cycle start+completion leaves outstanding unchanged.
- Backpressure: cont_hold=1 for 10 cycles while ap_done=1 → ap_continue=0, done_cnt frozen, finish waits; releasing cont_hold completes with done_cnt=trans_num.
- Zero count: go=1, trans_num=0 → FINISH next cycle, ap_start never asserted; go=0 → IDLE, finish=0.
- Spurious done: ap_done=1 in RUN before any start → err=1, done_cnt stays 0. A new run from IDLE clears err.
- Reset mid-run: reset=0 after 2 of 5 starts → next cycle all outputs 0 and state IDLE; re-run with go completes all 5.
